aludec_mc: RTL and testbench

- Parametrised, registered successor to the combinational ALU control decoder.
- Decodes aluop/funct into an ALU control word and registers it at the ID/EX boundary with valid, stall and flush.
- Adds EOR/LSL/LSR and multi-cycle MUL/SDIV; MUL/SDIV are sequenced by a counter FSM that requests a pipeline stall until the operation completes.
- Sits between the main decoder and the ID/EX register of the pipelined processor.

---
 rtl/aludec_pkg.sv | 52 +++++
 rtl/aludec_mc_comb.sv | 47 ++++
 rtl/aludec_mc.sv | 141 ++++++++++++++
 tb/tb_aludec_mc.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/aludec_pkg.sv
// Shared types and constants for the registered ALU control decoder.
// ALUDEC_DIV_EN enables the multi-cycle SDIV decode.
package aludec_pkg;

  localparam int unsigned FUNCT_W = 11;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned CODE_W  = 4;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_R2  = 2'b11
  } aluop_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 11'b10001011000;
  // ADDI ignores funct[0]; only bits [10:1] are compared
  localparam logic [FUNCT_W-1:0] FUNCT_ADDI = 11'b10010001000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 11'b11001011000;
  localparam logic [FUNCT_W-1:0] FUNCT_AND  = 11'b10001010000;
  localparam logic [FUNCT_W-1:0] FUNCT_ORR  = 11'b10101010000;
  localparam logic [FUNCT_W-1:0] FUNCT_EOR  = 11'b11001010000;
  localparam logic [FUNCT_W-1:0] FUNCT_LSL  = 11'b11010011011;
  localparam logic [FUNCT_W-1:0] FUNCT_LSR  = 11'b11010011010;
  localparam logic [FUNCT_W-1:0] FUNCT_MUL  = 11'b10011011000;
  localparam logic [FUNCT_W-1:0] FUNCT_SDIV = 11'b10011010110;

  localparam logic [CODE_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [CODE_W-1:0] ALU_ORR  = 4'b0001;
  localparam logic [CODE_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [CODE_W-1:0] ALU_EOR  = 4'b0011;
  localparam logic [CODE_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [CODE_W-1:0] ALU_BR   = 4'b0111;
  localparam logic [CODE_W-1:0] ALU_LSL  = 4'b1000;
  localparam logic [CODE_W-1:0] ALU_LSR  = 4'b1001;
  localparam logic [CODE_W-1:0] ALU_MUL  = 4'b1010;
  localparam logic [CODE_W-1:0] ALU_SDIV = 4'b1011;

  function automatic logic is_multicycle(input logic [CODE_W-1:0] code);
`ifdef ALUDEC_DIV_EN
    return (code == ALU_MUL) || (code == ALU_SDIV);
`else
    return (code == ALU_MUL);
`endif
  endfunction

endpackage

// File: rtl/aludec_mc_comb.sv
// Pure ALU control decode: aluop/funct -> code, illegal flag, multi-cycle flag.
// ALUDEC_DIV_EN enables SDIV; otherwise its funct decodes as illegal.
module aludec_mc_comb
  import aludec_pkg::*;
(
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CODE_W-1:0]  code,
  output logic               illegal,
  output logic               multicycle
);

  always_comb begin
    code    = ALU_AND;
    illegal = 1'b0;
    case (aluop)
      ALUOP_MEM: code = ALU_ADD;
      ALUOP_BR:  code = ALU_BR;
      default: begin
        if (funct[FUNCT_W-1:1] == FUNCT_ADDI[FUNCT_W-1:1]) begin
          code = ALU_ADD;
        end else begin
          case (funct)
            FUNCT_ADD:  code = ALU_ADD;
            FUNCT_SUB:  code = ALU_SUB;
            FUNCT_AND:  code = ALU_AND;
            FUNCT_ORR:  code = ALU_ORR;
            FUNCT_EOR:  code = ALU_EOR;
            FUNCT_LSL:  code = ALU_LSL;
            FUNCT_LSR:  code = ALU_LSR;
            FUNCT_MUL:  code = ALU_MUL;
`ifdef ALUDEC_DIV_EN
            FUNCT_SDIV: code = ALU_SDIV;
`endif
            default: begin
              code    = ALU_AND;
              illegal = 1'b1;
            end
          endcase
        end
      end
    endcase
  end

  assign multicycle = is_multicycle(code);

endmodule

// File: rtl/aludec_mc.sv
// Registered ALU control decoder with multi-cycle MUL/SDIV sequencing and stall request.
// ALUDEC_DIV_EN enables multi-cycle SDIV with DIV_LAT cycles.
module aludec_mc
  import aludec_pkg::*;
#(
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [10:0]       funct,
  input  logic [1:0]        aluop,
  input  logic              stall_in,
  input  logic              flush,
  output logic              out_valid,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              illegal,
  output logic              mc_busy,
  output logic              stall_req,
  output logic              mc_done
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;

  // Reject parameter sets the counter or code width cannot represent
  if (CTRL_W < 4 || MUL_LAT < 1 || DIV_LAT < 1 || (32'd1 << CNT_W) <= MAX_LAT) begin : g_param_err
    $error("aludec_mc: invalid parameter set");
  end

  logic [CODE_W-1:0] dec_code;
  logic              dec_illegal;
  logic              dec_mc;

  aludec_mc_comb u_comb (
    .aluop      (aluop),
    .funct      (funct),
    .code       (dec_code),
    .illegal    (dec_illegal),
    .multicycle (dec_mc)
  );

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CNT_W-1:0]  mc_lat;
  logic              out_valid_nxt;
  logic [CTRL_W-1:0] alucontrol_nxt;
  logic              illegal_nxt;
  logic              mc_busy_nxt;
  logic              mc_done_nxt;
  logic              accept;

  assign accept = in_valid & ~stall_in & ~mc_busy;

  // Latency of the multi-cycle op currently being decoded
  always_comb begin
    mc_lat = CNT_W'(MUL_LAT);
`ifdef ALUDEC_DIV_EN
    if (dec_code == ALU_SDIV) mc_lat = CNT_W'(DIV_LAT);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      out_valid  <= 1'b0;
      alucontrol <= '0;
      illegal    <= 1'b0;
      mc_busy    <= 1'b0;
      mc_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      out_valid  <= out_valid_nxt;
      alucontrol <= alucontrol_nxt;
      illegal    <= illegal_nxt;
      mc_busy    <= mc_busy_nxt;
      mc_done    <= mc_done_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    out_valid_nxt  = out_valid;
    alucontrol_nxt = alucontrol;
    illegal_nxt    = illegal;
    mc_busy_nxt    = mc_busy;
    mc_done_nxt    = 1'b0;

    if (flush) begin
      state_nxt      = IDLE;
      cnt_nxt        = '0;
      out_valid_nxt  = 1'b0;
      alucontrol_nxt = '0;
      illegal_nxt    = 1'b0;
      mc_busy_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_valid_nxt  = 1'b1;
            alucontrol_nxt = CTRL_W'(dec_code);
            illegal_nxt    = dec_illegal;
            if (dec_mc) begin
              if (mc_lat > CNT_W'(1)) begin
                state_nxt   = BUSY;
                cnt_nxt     = mc_lat - CNT_W'(1);
                mc_busy_nxt = 1'b1;
              end else begin
                mc_done_nxt = 1'b1;
              end
            end
          end else if (!stall_in) begin
            out_valid_nxt = 1'b0;
          end
        end
        BUSY: begin
          // Counter is frozen while the hazard unit stalls the pipeline
          if (!stall_in) begin
            if (cnt == CNT_W'(1)) begin
              state_nxt   = IDLE;
              cnt_nxt     = '0;
              mc_busy_nxt = 1'b0;
              mc_done_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt - CNT_W'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign stall_req = mc_busy;

endmodule

// File: tb/tb_aludec_mc.sv
// Scoreboard bench for aludec_mc at default parameters (MUL_LAT=3, DIV_LAT=8).
// SDIV expectations follow ALUDEC_DIV_EN.
module tb_aludec_mc;

  localparam int unsigned CTRL_W = 4;

  localparam logic [10:0] F_ADD  = 11'b10001011000;
  localparam logic [10:0] F_ADDI = 11'b10010001001;
  localparam logic [10:0] F_SUB  = 11'b11001011000;
  localparam logic [10:0] F_AND  = 11'b10001010000;
  localparam logic [10:0] F_ORR  = 11'b10101010000;
  localparam logic [10:0] F_EOR  = 11'b11001010000;
  localparam logic [10:0] F_LSL  = 11'b11010011011;
  localparam logic [10:0] F_LSR  = 11'b11010011010;
  localparam logic [10:0] F_MUL  = 11'b10011011000;
  localparam logic [10:0] F_SDIV = 11'b10011010110;
  localparam logic [10:0] F_BAD  = 11'b11111111111;

  // expected word: {out_valid, alucontrol[3:0], illegal, mc_busy, stall_req, mc_done}
  typedef struct packed {
    logic        rst;
    logic        iv;
    logic [1:0]  op;
    logic [10:0] fn;
    logic        st;
    logic        fl;
    logic [8:0]  exp;
  } row_t;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [10:0]       funct;
  logic [1:0]        aluop;
  logic              stall_in;
  logic              flush;
  logic              out_valid;
  logic [CTRL_W-1:0] alucontrol;
  logic              illegal;
  logic              mc_busy;
  logic              stall_req;
  logic              mc_done;

  int   nvec = 0;
  int   nerr = 0;
  logic [8:0] sb[$];

  aludec_mc dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .funct      (funct),
    .aluop      (aluop),
    .stall_in   (stall_in),
    .flush      (flush),
    .out_valid  (out_valid),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .mc_busy    (mc_busy),
    .stall_req  (stall_req),
    .mc_done    (mc_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic row_t r(input logic rst, input logic iv, input logic [1:0] op,
                             input logic [10:0] fn, input logic st, input logic fl,
                             input logic ov, input logic [3:0] ctrl, input logic ill,
                             input logic busy, input logic done);
    row_t x;
    x.rst = rst; x.iv = iv; x.op = op; x.fn = fn; x.st = st; x.fl = fl;
    x.exp = {ov, ctrl, ill, busy, busy, done};
    return x;
  endfunction

  function automatic logic [8:0] observe();
    return {out_valid, alucontrol[3:0], illegal, mc_busy, stall_req, mc_done};
  endfunction

  task automatic drive(input row_t x);
    reset = x.rst; in_valid = x.iv; aluop = x.op; funct = x.fn;
    stall_in = x.st; flush = x.fl;
  endtask

  task automatic test_reset();
    row_t rows[$];
    logic [8:0] e, g;
    rows.push_back(r(1, 1, 2'b10, F_SUB, 0, 0, 0, 4'b0000, 0, 0, 0));
    rows.push_back(r(1, 1, 2'b10, F_MUL, 0, 0, 0, 4'b0000, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); g = observe(); nvec++;
      if (g !== e) begin
        nerr++;
        $display("FAIL reset[%0d]: got %b expected %b (ov,ctrl,ill,busy,sreq,done)", i, g, e);
      end
    end
  endtask

  task automatic test_decode();
    row_t rows[$];
    logic [8:0] e, g;
    rows.push_back(r(0, 1, 2'b10, F_SUB,  0, 0, 1, 4'b0110, 0, 0, 0));
    rows.push_back(r(0, 1, 2'b10, F_BAD,  0, 0, 1, 4'b0000, 1, 0, 0));
    rows.push_back(r(0, 1, 2'b00, F_BAD,  0, 0, 1, 4'b0010, 0, 0, 0));
    rows.push_back(r(0, 1, 2'b01, F_SUB,  0, 0, 1, 4'b0111, 0, 0, 0));
    rows.push_back(r(0, 1, 2'b11, F_EOR,  0, 0, 1, 4'b0011, 0, 0, 0));
    rows.push_back(r(0, 1, 2'b10, F_LSL,  0, 0, 1, 4'b1000, 0, 0, 0));
    rows.push_back(r(0, 1, 2'b10, F_LSR,  0, 0, 1, 4'b1001, 0, 0, 0));
    rows.push_back(r(0, 1, 2'b10, F_ADDI, 0, 0, 1, 4'b0010, 0, 0, 0));
    rows.push_back(r(0, 0, 2'b10, F_SUB,  0, 0, 0, 4'b0010, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); g = observe(); nvec++;
      if (g !== e) begin
        nerr++;
        $display("FAIL decode[%0d]: got %b expected %b (ov,ctrl,ill,busy,sreq,done)", i, g, e);
      end
    end
  endtask

  task automatic test_mul();
    row_t rows[$];
    logic [8:0] e, g;
    rows.push_back(r(0, 1, 2'b10, F_MUL, 0, 0, 1, 4'b1010, 0, 1, 0));
    rows.push_back(r(0, 1, 2'b10, F_SUB, 0, 0, 1, 4'b1010, 0, 1, 0));
    rows.push_back(r(0, 1, 2'b10, F_SUB, 0, 0, 1, 4'b1010, 0, 0, 1));
    rows.push_back(r(0, 1, 2'b10, F_ADD, 0, 0, 1, 4'b0010, 0, 0, 0));
    rows.push_back(r(0, 0, 2'b10, F_ADD, 0, 0, 0, 4'b0010, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); g = observe(); nvec++;
      if (g !== e) begin
        nerr++;
        $display("FAIL mul[%0d]: got %b expected %b (ov,ctrl,ill,busy,sreq,done)", i, g, e);
      end
    end
  endtask

  task automatic test_mul_stall();
    row_t rows[$];
    logic [8:0] e, g;
    rows.push_back(r(0, 1, 2'b10, F_MUL, 0, 0, 1, 4'b1010, 0, 1, 0));
    rows.push_back(r(0, 0, 2'b10, F_ADD, 1, 0, 1, 4'b1010, 0, 1, 0));
    rows.push_back(r(0, 1, 2'b10, F_ADD, 1, 0, 1, 4'b1010, 0, 1, 0));
    rows.push_back(r(0, 0, 2'b10, F_ADD, 0, 0, 1, 4'b1010, 0, 1, 0));
    rows.push_back(r(0, 0, 2'b10, F_ADD, 0, 0, 1, 4'b1010, 0, 0, 1));
    rows.push_back(r(0, 0, 2'b10, F_ADD, 0, 0, 0, 4'b1010, 0, 0, 0));
    rows.push_back(r(0, 1, 2'b10, F_ADD, 1, 0, 0, 4'b1010, 0, 0, 0));
    rows.push_back(r(0, 1, 2'b10, F_ADD, 0, 0, 1, 4'b0010, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); g = observe(); nvec++;
      if (g !== e) begin
        nerr++;
        $display("FAIL mul_stall[%0d]: got %b expected %b (ov,ctrl,ill,busy,sreq,done)", i, g, e);
      end
    end
  endtask

  task automatic test_flush();
    row_t rows[$];
    logic [8:0] e, g;
`ifdef ALUDEC_DIV_EN
    rows.push_back(r(0, 1, 2'b10, F_SDIV, 0, 0, 1, 4'b1011, 0, 1, 0));
    rows.push_back(r(0, 0, 2'b10, F_ADD,  0, 0, 1, 4'b1011, 0, 1, 0));
    rows.push_back(r(0, 1, 2'b10, F_ADD,  0, 1, 0, 4'b0000, 0, 0, 0));
    for (int k = 0; k < 8; k++)
      rows.push_back(r(0, 0, 2'b10, F_ADD, 0, 0, 0, 4'b0000, 0, 0, 0));
`else
    rows.push_back(r(0, 1, 2'b10, F_SDIV, 0, 0, 1, 4'b0000, 1, 0, 0));
    rows.push_back(r(0, 0, 2'b10, F_ADD,  0, 0, 0, 4'b0000, 1, 0, 0));
`endif
    rows.push_back(r(0, 1, 2'b10, F_MUL, 0, 0, 1, 4'b1010, 0, 1, 0));
    rows.push_back(r(0, 1, 2'b10, F_SUB, 1, 1, 0, 4'b0000, 0, 0, 0));
    rows.push_back(r(0, 0, 2'b10, F_SUB, 0, 0, 0, 4'b0000, 0, 0, 0));
    rows.push_back(r(0, 0, 2'b10, F_SUB, 0, 0, 0, 4'b0000, 0, 0, 0));
    rows.push_back(r(0, 1, 2'b10, F_MUL, 0, 0, 1, 4'b1010, 0, 1, 0));
    rows.push_back(r(1, 0, 2'b10, F_SUB, 0, 0, 0, 4'b0000, 0, 0, 0));
    rows.push_back(r(0, 0, 2'b10, F_SUB, 0, 0, 0, 4'b0000, 0, 0, 0));
    rows.push_back(r(0, 0, 2'b10, F_SUB, 0, 0, 0, 4'b0000, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); g = observe(); nvec++;
      if (g !== e) begin
        nerr++;
        $display("FAIL flush[%0d]: got %b expected %b (ov,ctrl,ill,busy,sreq,done)", i, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    logic [8:0] e, g;
    rows.push_back(r(0, 1, 2'b10, F_ADD, 0, 0, 1, 4'b0010, 0, 0, 0));
    rows.push_back(r(0, 1, 2'b10, F_AND, 0, 0, 1, 4'b0000, 0, 0, 0));
    rows.push_back(r(0, 1, 2'b10, F_ORR, 0, 0, 1, 4'b0001, 0, 0, 0));
    rows.push_back(r(0, 0, 2'b10, F_SUB, 0, 0, 0, 4'b0001, 0, 0, 0));
    rows.push_back(r(0, 1, 2'b10, F_ADD, 0, 0, 1, 4'b0010, 0, 0, 0));
    foreach (rows[i]) begin
      drive(rows[i]); sb.push_back(rows[i].exp);
      @(posedge clk); #1;
      e = sb.pop_front(); g = observe(); nvec++;
      if (g !== e) begin
        nerr++;
        $display("FAIL back_to_back[%0d]: got %b expected %b (ov,ctrl,ill,busy,sreq,done)", i, g, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; aluop = 2'b00; funct = '0;
    stall_in = 1'b0; flush = 1'b0;
    test_reset();
    test_decode();
    test_mul();
    test_mul_stall();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
